// File: rtl/traffic_pkg.sv
// Shared phase, fault and monitor-state definitions for the traffic light path.
package traffic_pkg;

  // Light-phase codes on the generator-to-monitor bus
  localparam logic [1:0] PH_RED     = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;
  localparam logic [1:0] PH_ILLEGAL = 2'b11;

  // Latched fault causes
  localparam logic [2:0] FLT_NONE           = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL_CODE   = 3'd1;
  localparam logic [2:0] FLT_BAD_TRANSITION = 3'd2;
  localparam logic [2:0] FLT_DWELL_SHORT    = 3'd3;
  localparam logic [2:0] FLT_DWELL_LONG     = 3'd4;

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  // The single legal successor of each phase; ILLEGAL has none.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:    next_phase = PH_GREEN;
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      default:   next_phase = PH_ILLEGAL;
    endcase
  endfunction

  // One-hot lamp pattern {red, yellow, green} for a phase code.
  function automatic logic [2:0] lamp_onehot(input logic [1:0] ph);
    case (ph)
      PH_RED:    lamp_onehot = 3'b100;
      PH_YELLOW: lamp_onehot = 3'b010;
      PH_GREEN:  lamp_onehot = 3'b001;
      default:   lamp_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_monitor_blink_divider.sv
// Half-period divider for the flashing-red pattern.
// The blink output runs one cycle ahead of the lamp: the lamp register is set
// lit on restart and then copies blink each cycle, so restart preloads the
// state reached after the first lit cycle.
module blink_divider #(
  parameter int unsigned HALF = 3
) (
  input  logic clk,
  input  logic restart,
  input  logic enable,
  output logic blink
);

  localparam int unsigned W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST       = W'(HALF - 1);
  localparam logic [W-1:0] PRESET_CNT = (HALF == 1) ? W'(0) : W'(1);
  localparam logic         PRESET_BLK = (HALF != 1);

  logic [W-1:0] cnt;

  // Count cycles within a half-period and toggle blink at its end
  always_ff @(posedge clk) begin
    if (restart) begin
      cnt   <= PRESET_CNT;
      blink <= PRESET_BLK;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_monitor.sv
// Consumer-side phase checker: validates phase order and dwell times,
// drives the lamps, and latches a flashing-red fault on any violation.
module traffic_phase_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 8,
  parameter int unsigned YELLOW_MIN = 2,
  parameter int unsigned YELLOW_MAX = 3,
  parameter int unsigned RED_MIN    = 4,
  parameter int unsigned RED_MAX    = 8,
  parameter int unsigned BLINK_HALF = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       phase_in,
  input  logic             clear_fault,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count
);

  mon_state_t       state;
  logic [1:0]       prev_phase;
  logic [CNT_W-1:0] dwell;
  logic             first;

  logic [CNT_W-1:0] min_dwell;
  logic [CNT_W-1:0] max_dwell;
  logic [2:0]       run_code;
  logic             blink;
  logic             blink_restart;
  logic             blink_enable;

  // Dwell limits of the phase currently being held
  always_comb begin
    min_dwell = CNT_W'(RED_MIN);
    max_dwell = CNT_W'(RED_MAX);
    case (prev_phase)
      PH_GREEN: begin
        min_dwell = CNT_W'(GREEN_MIN);
        max_dwell = CNT_W'(GREEN_MAX);
      end
      PH_YELLOW: begin
        min_dwell = CNT_W'(YELLOW_MIN);
        max_dwell = CNT_W'(YELLOW_MAX);
      end
      default: ;
    endcase
  end

  // Fault classification for the current sample, highest priority first
  always_comb begin
    run_code = FLT_NONE;
    if (phase_in == PH_ILLEGAL) begin
      run_code = FLT_ILLEGAL_CODE;
    end else if (phase_in != prev_phase) begin
      if (phase_in != next_phase(prev_phase)) begin
        run_code = FLT_BAD_TRANSITION;
      end else if (!first && (dwell < min_dwell)) begin
        run_code = FLT_DWELL_SHORT;
      end
    end else if (dwell == max_dwell) begin
      run_code = FLT_DWELL_LONG;
    end
  end

  // Restart the flash from its lit phase whenever a flashing state is entered
  always_comb begin
    blink_restart = reset
                 || ((state == MON_RUN) && (run_code != FLT_NONE))
                 || ((state == MON_FAULT) && clear_fault);
    blink_enable  = (state != MON_RUN);
  end

  blink_divider #(
    .HALF (BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .restart (blink_restart),
    .enable  (blink_enable),
    .blink   (blink)
  );

  // Monitor FSM with registered lamp, fault and cycle-count outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MON_INIT;
      prev_phase  <= PH_RED;
      dwell       <= '0;
      first       <= 1'b0;
      lamp_red    <= 1'b1;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FLT_NONE;
      cycle_count <= '0;
    end else begin
      case (state)
        MON_INIT: begin
          if (phase_in != PH_ILLEGAL) begin
            state      <= MON_RUN;
            prev_phase <= phase_in;
            dwell      <= CNT_W'(1);
            first      <= 1'b1;
            {lamp_red, lamp_yellow, lamp_green} <= lamp_onehot(phase_in);
          end else begin
            {lamp_red, lamp_yellow, lamp_green} <= {blink, 2'b00};
          end
        end
        MON_RUN: begin
          if (run_code != FLT_NONE) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            fault_code <= run_code;
            {lamp_red, lamp_yellow, lamp_green} <= 3'b100;
          end else begin
            {lamp_red, lamp_yellow, lamp_green} <= lamp_onehot(phase_in);
            if (phase_in != prev_phase) begin
              dwell      <= CNT_W'(1);
              first      <= 1'b0;
              prev_phase <= phase_in;
              // Only RED can legally precede GREEN, so this marks a completed cycle
              if (prev_phase == PH_RED) begin
                cycle_count <= cycle_count + CNT_W'(1);
              end
            end else begin
              dwell <= dwell + CNT_W'(1);
            end
          end
        end
        MON_FAULT: begin
          if (clear_fault) begin
            state      <= MON_INIT;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            {lamp_red, lamp_yellow, lamp_green} <= 3'b100;
          end else begin
            {lamp_red, lamp_yellow, lamp_green} <= {blink, 2'b00};
          end
        end
        default: begin
          state <= MON_INIT;
        end
      endcase
    end
  end

endmodule
